cont_8b: RTL and testbench
==========================

// Module: cont_8b
// PURPOSE
//  - Free-running 8-bit binary up-counter with synchronous reset and count enable.
//  - Generic utility block for event/cycle counting and simple timebase generation.
//  - Single clock domain; output is driven directly from the count register.
// PARAMETERS
//  - WIDTH   8   Counter width in bits. Qdata is WIDTH bits wide; WIDTH >= 1.
// PORTS
//  - clk    in   1      Clock; all state changes on the rising edge.
//  - rst    in   1      Synchronous reset, active-high: one clock, sync active-high reset.
//  - ena    in   1      Count enable, active-high.
//  - Qdata  out  WIDTH  Current count value, registered.
// BEHAVIOUR
//  - Evaluated only at posedge clk; priority order:
//      1. rst==1          -> Qdata <= 0
//      2. rst==0, ena==1  -> Qdata <= Qdata + 1, modulo 2**WIDTH
//      3. rst==0, ena==0  -> Qdata holds its value
//  - rst has priority over ena. Asserting both gives Qdata = 0, with no increment.
//  - Reset is synchronous. Changing rst between clock edges has no effect on Qdata.
//  - Reset value of Qdata: all zeros, visible after the first posedge with rst=1.
//  - Before the first reset edge, Qdata is undefined. There is no power-on initial value.
//  - Latency:
//      - Qdata reflects rst/ena one clock after the sampling edge.
//      - No combinational path from any input to Qdata.
//  - Arithmetic: unsigned, width WIDTH. No carry-out or overflow port.
//  - Wrap-around: 8'hFF + ena -> 8'h00 on the next edge, with no stall or saturation.
//  - Reset mid-count: on the next edge Qdata goes to 0 regardless of the current value.
//      - Counting resumes from 0 on the first edge where rst=0 and ena=1.
//  - Enable:
//      - Enable is level-sensitive. Each clock with ena=1 adds exactly 1.
//      - Toggling ena does not cause extra counts.
//  - X/Z on ena while rst=0 is not a supported operating condition.
// STRUCTURE
//  - One module, one always block at posedge clk holding the WIDTH-bit register.
//  - No sub-module: next-state logic is a single adder/mux.
//  - No shared package required.
//  - If a package exists for counters, it holds only the default WIDTH constant (8).
// TESTING  (20 ns clock period; sample Qdata after each posedge)
//  - Reset, no enable:
//      - rst=1, ena=0 for 2 clks -> Qdata = 8'h00.
//      - Then rst=0, ena=0 for 5 clks -> Qdata stays 8'h00.
//  - Count:
//      - After reset, rst=0, ena=1 for 10 clks -> Qdata = 8'd10, incrementing by 1 per clk.
//  - Hold:
//      - From Qdata=10, ena=0 for 4 clks -> Qdata stays 10.
//      - Then ena=1 for 1 clk -> Qdata = 11.
//  - Wrap:
//      - From reset, ena=1 for 256 clks -> Qdata = 8'h00.
//      - Qdata = 8'hFF after the 255th clk.
//  - Priority:
//      - At Qdata=37, rst=1 and ena=1 together for 1 clk -> Qdata = 0, not 38.
//      - Then rst=0 -> 1, 2, 3 on successive clks.
//  - Sync reset:
//      - Pulse rst high for 5 ns between edges while counting -> Qdata is unaffected.
//      - Counting continues with no reset.

Source files
------------

// File: rtl/cont_8b_pkg.sv
//------------------------------------------------------------------------------
// Module  : cont_8b_pkg
// Brief   : Shared default width for the cont_8b counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cont_8b_pkg;
  localparam int c_DEFAULT_WIDTH = 8;
endpackage

`default_nettype wire

// File: rtl/cont_8b.sv
//------------------------------------------------------------------------------
// Module  : cont_8b
// Brief   : Free-running WIDTH-bit up-counter with sync reset and count enable.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cont_8b
  import cont_8b_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [WIDTH-1:0] Qdata
);

  logic [WIDTH-1:0] r_count;

  // Reset wins over enable; the increment wraps naturally at 2**WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (ena) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign Qdata = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cont_8b.sv
//------------------------------------------------------------------------------
// Module  : tb_cont_8b
// Brief   : Self-checking bench for cont_8b (directed scenarios plus random).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cont_8b;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] Qdata;

  int total;
  int bad;
  // Reference: number of enabled cycles since the last reset edge.
  int enables_since_reset;

  cont_8b #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .Qdata (Qdata)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_value();
    return 8'(enables_since_reset % 256);
  endfunction

  // Apply inputs for one clock, then compare 1 ns after the edge.
  task automatic step(input logic r, input logic e, input string tag);
    rst = r;
    ena = e;
    @(posedge clk);
    #1;
    if (r) enables_since_reset = 0;
    else if (e) enables_since_reset++;
    chk(tag, Qdata, model_value());
  endtask

  initial begin
    total = 0;
    bad   = 0;
    enables_since_reset = 0;
    rst = 1'b1;
    ena = 1'b0;

    // Reset, no enable
    repeat (2) step(1'b1, 1'b0, "reset");
    chk("reset_zero", Qdata, 8'h00);
    repeat (5) step(1'b0, 1'b0, "idle_hold");
    chk("idle_zero", Qdata, 8'h00);

    // Count 10, hold, then one more
    repeat (10) step(1'b0, 1'b1, "count");
    chk("count10", Qdata, 8'd10);
    repeat (4) step(1'b0, 1'b0, "hold");
    chk("hold10", Qdata, 8'd10);
    step(1'b0, 1'b1, "resume");
    chk("count11", Qdata, 8'd11);

    // Wrap from reset
    step(1'b1, 1'b0, "wrap_reset");
    repeat (255) step(1'b0, 1'b1, "wrap_count");
    chk("wrap_ff", Qdata, 8'hFF);
    step(1'b0, 1'b1, "wrap_edge");
    chk("wrap_00", Qdata, 8'h00);

    // Reset priority over enable at 37
    step(1'b1, 1'b0, "prio_reset");
    repeat (37) step(1'b0, 1'b1, "prio_count");
    chk("prio_37", Qdata, 8'd37);
    step(1'b1, 1'b1, "prio_both");
    chk("prio_zero", Qdata, 8'h00);
    step(1'b0, 1'b1, "prio_after");
    chk("prio_1", Qdata, 8'd1);
    step(1'b0, 1'b1, "prio_after");
    chk("prio_2", Qdata, 8'd2);
    step(1'b0, 1'b1, "prio_after");
    chk("prio_3", Qdata, 8'd3);

    // Reset glitch between edges must not disturb the count
    repeat (6) begin
      #4 rst = 1'b1;
      #5 rst = 1'b0;
      step(1'b0, 1'b1, "glitch_count");
    end
    chk("glitch_9", Qdata, 8'd9);

    // Random rst/ena traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
